mips_mmio_uart_tx: RTL and testbench

- Memory-mapped serial transmit peripheral on the mini-MIPS bus, downstream of the CPU core.
- Consumes the core's memwrite, adr and writedata outputs and decodes a 16-byte window at BASE_ADDR.
- Buffers written bytes in a small FIFO and shifts them out as 8N1 UART frames.
- Returns a status byte to the system read mux.

---
 rtl/mips_periph_pkg.sv | 22 ++
 rtl/mips_sync_fifo.sv | 63 ++++++
 rtl/mips_mmio_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_mips_mmio_uart_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_periph_pkg.sv
// Shared types and constants for the mini-MIPS memory-mapped peripherals.
package mips_periph_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h1;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT   = 3;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/mips_sync_fifo.sv
// Parameterised synchronous circular-buffer FIFO; push while full is accepted only alongside a pop.
module mips_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_nxt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign pop_ok      = pop_i && !empty_o;
  assign push_ok     = push_i && (!full_o || pop_ok);
  assign dout_o      = mem_q[rptr_q];
  assign count_nxt_o = count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mips_mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS decode, byte FIFO and 8N1 serialiser.
// Define MIPS_UART_PARITY_EN to insert an even-parity bit between data and stop.
module mips_mmio_uart_tx
  import mips_periph_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR    = 8'hF0,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memwrite,
  input  logic [7:0] adr,
  input  logic [7:0] writedata,
  output logic       sel,
  output logic [7:0] rdata,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       offset;
  logic             push, pop, ovf_clr, ovf_set, baud_end;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count_nxt;
  logic [7:0]       status;

  // Address decode and register read path, fully combinational.
  assign offset  = adr[3:0];
  assign sel     = (adr[7:4] == BASE_ADDR[7:4]);
  assign push    = memwrite && sel && (offset == TXDATA_OFF);
  assign ovf_clr = memwrite && sel && (offset == STATUS_OFF) && writedata[STAT_OVF_BIT];
  assign ovf_set = push && fifo_full && !pop;

  always_comb begin
    status                 = '0;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_BUSY_BIT]  = busy_q;
    status[STAT_OVF_BIT]   = ovf_q;
  end

  assign rdata = (sel && (offset == STATUS_OFF)) ? status : 8'h00;

  mips_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .din_i       (writedata),
    .dout_o      (fifo_dout),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_nxt_o (fifo_count_nxt)
  );

  // Sticky overflow; a same-cycle set beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  assign baud_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  // Transmit FSM; tx and busy are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef MIPS_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef MIPS_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[bit_d];
`ifdef MIPS_UART_PARITY_EN
      ST_PARITY: tx_d = ^shreg_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE) || (fifo_count_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mips_mmio_uart_tx.sv
// Bench for mips_mmio_uart_tx: directed and random bus writes against a queue-based line model.
module tb_mips_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       memwrite  = 1'b0;
  logic [7:0] adr       = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic       sel;
  logic [7:0] rdata;
  logic       tx;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model: pending bytes, remaining per-cycle line levels of the frame in flight, sticky overflow.
  byte unsigned m_fifo[$];
  bit           m_line[$];
  bit           m_tx   = 1'b1;
  bit           m_busy = 1'b0;
  bit           m_ovf  = 1'b0;

  always #5 clk = ~clk;

  mips_mmio_uart_tx #(
    .BASE_ADDR    (8'hF0),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .sel       (sel),
    .rdata     (rdata),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  function automatic logic [7:0] exp_status();
    logic full_b, empty_b;
    full_b  = (m_fifo.size() == int'(DEPTH));
    empty_b = (m_fifo.size() == 0);
    return {4'b0000, m_ovf, m_busy, full_b, empty_b};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_line.delete();
    m_tx   = 1'b1;
    m_busy = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic load_frame(input byte unsigned b);
    for (int k = 0; k < int'(CPB); k++) m_line.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < int'(CPB); k++) m_line.push_back(b[i]);
`ifdef MIPS_UART_PARITY_EN
    for (int k = 0; k < int'(CPB); k++) m_line.push_back(^b);
`endif
    for (int k = 0; k < int'(CPB); k++) m_line.push_back(1'b1);
  endtask

  // One rising edge: a frame starts whenever the line is free and a byte was waiting before the edge.
  task automatic model_edge(input logic we, input logic [7:0] a, input logic [7:0] d);
    bit in_win, push_b, clr_b, full_pre, popped, emitted;
    if (!reset) begin
      model_reset();
      return;
    end
    in_win   = (a[7:4] == 4'hF);
    push_b   = we && in_win && (a[3:0] == 4'h0);
    clr_b    = we && in_win && (a[3:0] == 4'h1) && d[3];
    full_pre = (m_fifo.size() == int'(DEPTH));
    popped   = 1'b0;
    if (m_line.size() == 0 && m_fifo.size() != 0) begin
      load_frame(m_fifo.pop_front());
      popped = 1'b1;
    end
    if (clr_b) m_ovf = 1'b0;
    if (push_b) begin
      if (full_pre && !popped) m_ovf = 1'b1;
      else m_fifo.push_back(d);
    end
    emitted = 1'b0;
    if (m_line.size() != 0) begin
      m_tx    = m_line.pop_front();
      emitted = 1'b1;
    end else begin
      m_tx = 1'b1;
    end
    m_busy = emitted || (m_fifo.size() != 0);
  endtask

  // Entered just after a falling edge; drives one bus cycle and checks both read path and line.
  task automatic step(input logic we, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] exp_rd;
    memwrite  = we;
    adr       = a;
    writedata = d;
    #1;
    exp_rd = (a[7:4] == 4'hF && a[3:0] == 4'h1) ? exp_status() : 8'h00;
    check_eq("sel", 32'(sel), 32'(a[7:4] == 4'hF));
    check_eq("rdata", 32'(rdata), 32'(exp_rd));
    @(posedge clk);
    model_edge(we, a, d);
    @(negedge clk);
    check_eq("tx", 32'(tx), 32'(m_tx));
    check_eq("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'hF1, 8'h00);
  endtask

  initial begin
    logic [7:0] ra, rd;
    logic       rw;

    repeat (3) @(negedge clk);
    adr = 8'hF1;
    #1;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_status", 32'(rdata), 32'h01);
    reset = 1'b1;
    idle(4);

    // Single frame of 0x55.
    step(1'b1, 8'hF0, 8'h55);
    idle(48);

    // Back-to-back writes give contiguous frames.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hF0, 8'(8'hA1 + i));
    idle(180);

    // Overrun while a frame is in flight, then clear overflow.
    step(1'b1, 8'hF0, 8'hC0);
    idle(6);
    for (int i = 0; i < 6; i++) step(1'b1, 8'hF0, 8'($urandom));
    idle(2);
    check_eq("ovf_set", 32'(rdata[3]), 32'd1);
    step(1'b1, 8'hF1, 8'h08);
    idle(2);
    check_eq("ovf_clr", 32'(rdata[3]), 32'd0);
    idle(230);

    // Parity-relevant bytes (odd and even weight), window aliases and ignored offsets.
    step(1'b1, 8'hF0, 8'h07);
    step(1'b1, 8'hF0, 8'h03);
    step(1'b1, 8'hF5, 8'hEE);
    step(1'b1, 8'hE0, 8'hEE);
    idle(100);

    // Asynchronous reset in the middle of the data bits.
    step(1'b1, 8'hF0, 8'h3C);
    step(1'b1, 8'hF0, 8'h5A);
    idle(12);
    memwrite = 1'b0;
    adr      = 8'hF1;
    reset    = 1'b0;
    #1;
    check_eq("async_tx", 32'(tx), 32'd1);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_status", 32'(rdata), 32'h01);
    model_reset();
    idle(2);
    reset = 1'b1;
    idle(60);

    // Random bus traffic.
    for (int i = 0; i < 600; i++) begin
      rw = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    ra = 8'hF0;
        2:       ra = 8'hF1;
        default: ra = 8'($urandom);
      endcase
      rd = 8'($urandom);
      step(rw, ra, rd);
    end
    idle(260);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
